// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and helpers.
// Combinational only; no latency.
// No flow control.
package cpu_pkg;
  localparam int WORD_W = 32;

  // A select port is never narrower than one bit, even for degenerate N.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N:1 word select; an out-of-range sel forwards input 0.
// Latency: 0 cycles.
// Backpressure: none.
module mux_n_comb import cpu_pkg::*; #(
  parameter int DATA_W = WORD_W,
  parameter int N_IN   = 4,
  localparam int SEL_W = clog2_min1(N_IN)
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic [DATA_W-1:0]      out_data
);

  always_comb begin
    out_data = in_data[DATA_W-1:0];
    for (int k = 1; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) out_data = in_data[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 operand select with a registered valid/ready output stage; MUXN_SKID_EN adds a skid entry.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = !skid_vld (flop) with MUXN_SKID_EN, else !out_valid | out_ready.
module mux_n_pipe import cpu_pkg::*; #(
  parameter int DATA_W = WORD_W,
  parameter int N_IN   = 4,
  localparam int SEL_W = clog2_min1(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   sel_err
);

  logic [DATA_W-1:0] mux_dat;
  logic              sel_oor;
  logic              accept;

  mux_n_comb #(.DATA_W(DATA_W), .N_IN(N_IN)) u_mux (
    .sel      (sel),
    .in_data  (in_data),
    .out_data (mux_dat)
  );

  // Only reachable when N_IN is not a power of two.
  assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(N_IN));
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else if (accept && sel_oor) sel_err <= 1'b1;
  end

`ifdef MUXN_SKID_EN
  logic              skid_vld;
  logic [DATA_W-1:0] skid_dat;
  logic [SEL_W-1:0]  skid_sel;

  assign in_ready = !skid_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      skid_vld  <= 1'b0;
      skid_dat  <= '0;
      skid_sel  <= '0;
    end else if (out_valid && out_ready) begin
      // Skid full implies in_ready was low, so no accept competes with the refill.
      if (skid_vld) begin
        out_data <= skid_dat;
        out_sel  <= skid_sel;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_data <= mux_dat;
        out_sel  <= sel;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (!out_valid) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= mux_dat;
        out_sel   <= sel;
      end
    end else if (accept) begin
      skid_vld <= 1'b1;
      skid_dat <= mux_dat;
      skid_sel <= sel;
    end
  end
`else
  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_dat;
      out_sel   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: directed tables on 4- and 3-input builds, randomized scoreboard on a 16x64 build.
// Works with or without MUXN_SKID_EN.
module tb_mux_n_pipe;
  logic clk;
  logic rst_n;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err;
  logic [1:0]   a_sel, a_out_sel;
  logic [127:0] a_in_data;
  logic [31:0]  a_out_data;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err;
  logic [1:0]   b_sel, b_out_sel;
  logic [95:0]  b_in_data;
  logic [31:0]  b_out_data;

  logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sel_err;
  logic [3:0]    c_sel, c_out_sel;
  logic [1023:0] c_in_data;
  logic [63:0]   c_out_data;

  int checks;
  int failures;

  mux_n_pipe #(.DATA_W(32), .N_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .sel(a_sel),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sel(a_out_sel), .sel_err(a_sel_err));

  mux_n_pipe #(.DATA_W(32), .N_IN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .sel(b_sel),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sel(b_out_sel), .sel_err(b_sel_err));

  mux_n_pipe #(.DATA_W(64), .N_IN(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .sel(c_sel),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_sel(c_out_sel), .sel_err(c_sel_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic        ordy;
    logic        rdy;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  os;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  s;
  } exp_t;

  vec_t tbl[10];
  exp_t q[$];

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_sel = 0;
    b_in_valid = 0; b_out_ready = 0; b_sel = 0;
    c_in_valid = 0; c_out_ready = 0; c_sel = 0;
    a_in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    b_in_data = {32'hC2, 32'hB1, 32'hA0};
    c_in_data = '0;

    // Single pick, then a 4-word stream stalled for three cycles.
    tbl[0] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h33, 2'd2};
    tbl[1] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0};
`ifdef MUXN_SKID_EN
    tbl[2] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h11, 2'd0};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 32'h11, 2'd0};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h11, 2'd0};
    tbl[5] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1};
`else
    tbl[2] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h11, 2'd0};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h11, 2'd0};
    tbl[4] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h11, 2'd0};
    tbl[5] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
`endif
    tbl[6] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h33, 2'd2};
    tbl[7] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 32'h44, 2'd3};
    tbl[8] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0};
    tbl[9] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0};

    #1;
    chk("reset_a_out_valid", a_out_valid, 0);
    chk("reset_a_out_data", a_out_data, 0);
    chk("reset_a_out_sel", a_out_sel, 0);
    chk("reset_a_sel_err", a_sel_err, 0);
    chk("reset_b_sel_err", b_sel_err, 0);
    chk("reset_c_out_valid", c_out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      a_in_valid = tbl[i].v;
      a_sel = tbl[i].s;
      a_out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), a_in_ready, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_out_valid", i), a_out_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_data", i), a_out_data, tbl[i].od);
        chk($sformatf("tbl%0d_out_sel", i), a_out_sel, tbl[i].os);
      end
    end

    // Out-of-range select on the 3-input build, then a legal one.
    b_in_valid = 1; b_sel = 2'd3; b_out_ready = 1;
    #1;
    chk("oor_in_ready", b_in_ready, 1);
    @(negedge clk);
    chk("oor_out_valid", b_out_valid, 1);
    chk("oor_out_data", b_out_data, 32'hA0);
    chk("oor_out_sel", b_out_sel, 3);
    chk("oor_sel_err", b_sel_err, 1);
    b_sel = 2'd1;
    @(negedge clk);
    chk("legal_out_data", b_out_data, 32'hB1);
    chk("sticky_sel_err", b_sel_err, 1);

    // Stall both builds with a word held, then reset asynchronously mid-cycle.
    b_sel = 2'd2; b_out_ready = 0;
    a_in_valid = 1; a_sel = 2'd3; a_out_ready = 0;
    @(negedge clk);
    b_in_valid = 0;
    a_sel = 2'd1;
    chk("stall_a_out_valid", a_out_valid, 1);
    chk("stall_a_out_data", a_out_data, 32'h44);
    chk("stall_b_out_valid", b_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_out_valid", a_out_valid, 0);
    chk("arst_a_out_data", a_out_data, 0);
    chk("arst_b_out_valid", b_out_valid, 0);
    chk("arst_b_sel_err", b_sel_err, 0);
    a_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_a_out_valid", a_out_valid, 0);
      chk("post_rst_b_out_valid", b_out_valid, 0);
    end
    chk("post_rst_a_in_ready", a_in_ready, 1);

    // Randomized stream against a queue of expected words.
    for (int i = 0; i < 10000; i++) begin
      logic exp_rdy;
      c_in_valid = ($urandom_range(0, 99) < 70);
      if (i >= 3000 && i < 6000) c_out_ready = 1'b1;
      else c_out_ready = ($urandom_range(0, 99) < 60);
      for (int k = 0; k < 16; k++) c_in_data[k*64 +: 64] = {$urandom, $urandom};
      c_sel = 4'($urandom_range(0, 15));
      #1;
`ifdef MUXN_SKID_EN
      exp_rdy = (q.size() < 2);
`else
      exp_rdy = (q.size() == 0) || c_out_ready;
`endif
      chk("rnd_in_ready", c_in_ready, exp_rdy);
      chk("rnd_out_valid", c_out_valid, q.size() != 0);
      if (c_out_valid && q.size() != 0) begin
        chk("rnd_out_data", c_out_data, q[0].d);
        chk("rnd_out_sel", c_out_sel, q[0].s);
        if (c_out_ready) void'(q.pop_front());
      end
      if (c_in_valid && c_in_ready) q.push_back('{c_in_data[int'(c_sel)*64 +: 64], c_sel});
      @(negedge clk);
    end
    chk("rnd_sel_err", c_sel_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
